demux32_bit_1to2_buf: RTL

//  Buffered 1-to-2 demultiplexer: the steering counterpart of the 2:1 32-bit mux.

---
 rtl/demux32_bit_1to2_buf.sv | 105 ++++++++++
 1 files changed

// File: rtl/demux32_bit_1to2_buf.sv
// Buffered 1-to-2 valid/ready demultiplexer with an independent FIFO per output.
// Optional delivered-word counters are enabled by defining DEMUX_COUNT_EN.
module demux32_bit_1to2_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] InData,
    input  logic             InSel,
    input  logic             InValid,
    output logic             InReady,
    output logic [WIDTH-1:0] OutA,
    output logic             OutAValid,
    input  logic             OutAReady,
    output logic [WIDTH-1:0] OutB,
    output logic             OutBValid,
    input  logic             OutBReady,
    output logic [15:0]      CountA,
    output logic [15:0]      CountB
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = AW + 1;

    logic [1:0]       full;
    logic [1:0]       valid;
    logic [1:0]       ready;
    logic [1:0]       pop;
    logic [WIDTH-1:0] head [2];

    assign ready   = {OutBReady, OutAReady};
    // Readiness follows only the selected side's fullness, never the consumers.
    assign InReady = Reset & ~full[InSel];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic [WIDTH-1:0] mem [DEPTH];
            logic [AW-1:0]    wr_ptr_reg;
            logic [AW-1:0]    rd_ptr_reg;
            logic [OW-1:0]    occ_reg;
            logic             push;

            assign push      = InValid & InReady & (InSel == 1'(gi));
            assign pop[gi]   = valid[gi] & ready[gi];
            assign full[gi]  = (occ_reg == OW'(DEPTH));
            assign valid[gi] = Reset & (occ_reg != '0);
            assign head[gi]  = valid[gi] ? mem[rd_ptr_reg] : '0;

            always_ff @(posedge Clk) begin
                if (push) begin
                    mem[wr_ptr_reg] <= InData;
                end
            end

            always_ff @(posedge Clk) begin
                if (!Reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    occ_reg    <= '0;
                end else begin
                    if (push) begin
                        wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + AW'(1);
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + AW'(1);
                    end
                    if (push && !pop[gi]) begin
                        occ_reg <= occ_reg + OW'(1);
                    end else if (!push && pop[gi]) begin
                        occ_reg <= occ_reg - OW'(1);
                    end
                end
            end
        end
    endgenerate

    assign OutA      = head[0];
    assign OutB      = head[1];
    assign OutAValid = valid[0];
    assign OutBValid = valid[1];

`ifdef DEMUX_COUNT_EN
    logic [15:0] count_reg [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_count
            // Saturating: a long-running stream pins at all-ones instead of wrapping.
            always_ff @(posedge Clk) begin
                if (!Reset) begin
                    count_reg[gi] <= '0;
                end else if (pop[gi] && count_reg[gi] != 16'hFFFF) begin
                    count_reg[gi] <= count_reg[gi] + 16'd1;
                end
            end
        end
    endgenerate

    assign CountA = Reset ? count_reg[0] : 16'h0;
    assign CountB = Reset ? count_reg[1] : 16'h0;
`else
    assign CountA = 16'h0;
    assign CountB = 16'h0;
`endif

endmodule
